// File: rtl/pulse_stretch_tx_pkg.sv
// Shared definitions for the strobe-link transmitter: FSM encoding, default phase widths
// (also used by the far-end receiver) and the queue counter width helper.
package pulse_stretch_tx_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHigh    = 2'd1,
    StWaitAck = 2'd2,
    StLow     = 2'd3
  } state_e;

  localparam int unsigned DefHighCycles = 4;
  localparam int unsigned DefLowCycles  = 2;
  localparam int unsigned DefPendMax    = 3;

  // Width of a counter holding 0..max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_tx_if.sv
// Strobe-link transmitter bus: request/acknowledge inputs and stretched-level status outputs.
interface pulse_stretch_tx_if
  import pulse_stretch_tx_pkg::*;
#(
  parameter int unsigned PEND_MAX = DefPendMax
) ();

  localparam int unsigned W = cnt_width(PEND_MAX);

  logic         trig;
  logic         ack;
  logic         out;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [W-1:0] pend_cnt;

  modport master (
    input  trig,
    input  ack,
    output out,
    output busy,
    output done,
    output overflow,
    output pend_cnt
  );

  modport slave (
    output trig,
    output ack,
    input  out,
    input  busy,
    input  done,
    input  overflow,
    input  pend_cnt
  );

endinterface

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter for queued triggers; inc+dec together holds, inc at full
// is dropped and reported as a one-cycle overflow pulse.
module sat_updown_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MAX   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  assign full     = (count_q == MaxVal);
  assign count    = count_q;
  assign overflow = overflow_q;

  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (inc && !dec) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/pulse_stretch_tx.sv
// Strobe-link transmitter: stretches each trig into a high phase (optionally held until ack)
// followed by a guaranteed low gap, queueing triggers that arrive while busy.
module pulse_stretch_tx
  import pulse_stretch_tx_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DefHighCycles,
  parameter int unsigned LOW_CYCLES  = DefLowCycles,
  parameter int unsigned PEND_MAX    = DefPendMax,
  parameter int unsigned USE_ACK     = 0
) (
  input logic                clk,
  input logic                reset,
  pulse_stretch_tx_if.master bus
);

  localparam int unsigned W        = cnt_width(PEND_MAX);
  localparam int unsigned PhaseMax = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned CW       = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;
  localparam logic [CW-1:0] HighLoad = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LowLoad  = CW'(LOW_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            cnt_zero;
  logic            q_inc, q_dec, q_full;
  logic [W-1:0]    pend;
  logic            unused_full;

  assign cnt_zero    = (cnt_q == '0);
  // A queued trigger is consumed on the last low cycle; an arriving trig there nets out.
  assign q_dec       = (state_q == StLow) && cnt_zero && (pend != '0);
  assign q_inc       = bus.trig && (state_q != StIdle);
  assign unused_full = q_full;

  sat_updown_counter #(
    .WIDTH (W),
    .MAX   (PEND_MAX)
  ) u_pend (
    .clk      (clk),
    .reset    (reset),
    .inc      (q_inc),
    .dec      (q_dec),
    .count    (pend),
    .full     (q_full),
    .overflow (bus.overflow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.trig) begin
          state_d = StHigh;
          cnt_d   = HighLoad;
        end
      end
      StHigh: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if ((USE_ACK != 0) && !bus.ack) begin
          state_d = StWaitAck;
        end else begin
          state_d = StLow;
          cnt_d   = LowLoad;
          done_d  = 1'b1;
        end
      end
      StWaitAck: begin
        if (bus.ack) begin
          state_d = StLow;
          cnt_d   = LowLoad;
          done_d  = 1'b1;
        end
      end
      StLow: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (pend != '0) begin
          state_d = StHigh;
          cnt_d   = HighLoad;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.out      = (state_q == StHigh) || (state_q == StWaitAck);
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.pend_cnt = pend;

endmodule

// File: tb/tb_pulse_stretch_tx.sv
// Bench for pulse_stretch_tx: directed timing scenarios plus a random loopback run into a
// falling-edge detector, checked against a pulse-schedule model.
module tb_pulse_stretch_tx;
  import pulse_stretch_tx_pkg::*;

  localparam int H    = 4;
  localparam int L    = 2;
  localparam int PMAX = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pulse_stretch_tx_if #(.PEND_MAX(PMAX)) if0 ();
  pulse_stretch_tx_if #(.PEND_MAX(PMAX)) if1 ();

  pulse_stretch_tx #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_MAX    (PMAX),
    .USE_ACK     (0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  pulse_stretch_tx #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_MAX    (PMAX),
    .USE_ACK     (1)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: each accepted pulse occupies H high + L low cycles from its start cycle.
  bit m_active;
  int m_start;
  int m_pend;
  int m_pulses;
  bit m_ovf;

  // Far-end falling-edge detector, sharing the link reset.
  logic det_prev  = 1'b0;
  int   det_falls = 0;
  int   low_run   = 0;
  bit   seen_fall = 1'b0;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      det_prev  = 1'b0;
      seen_fall = 1'b0;
      low_run   = 0;
    end else begin
      if (det_prev && !if0.out) begin
        det_falls++;
        seen_fall = 1'b1;
        low_run   = 0;
      end
      if (!if0.out) low_run++;
      if (!det_prev && if0.out && seen_fall) begin
        n_cmp++;
        assert ((low_run >= L) === 1'b1) else begin
          n_err++;
          $error("FAIL low_gap: observed %0d low cycles, expected >= %0d", low_run, L);
        end
      end
      det_prev = if0.out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_active = 1'b0;
    m_start  = 0;
    m_pend   = 0;
    m_pulses = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input bit t, input int e);
    bit last;
    bit deq;
    m_ovf = 1'b0;
    if (!m_active) begin
      if (t) begin
        m_active = 1'b1;
        m_start  = e;
        m_pulses++;
      end
    end else begin
      last = (e == m_start + H + L);
      deq  = last && (m_pend > 0);
      if (t && !deq) begin
        if (m_pend == PMAX) m_ovf = 1'b1;
        else m_pend++;
      end else if (deq && !t) begin
        m_pend--;
      end
      if (last) begin
        if (deq) begin
          m_start = e;
          m_pulses++;
        end else begin
          m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic chk_model();
    chk("m_out",  32'(if0.out),      32'(m_active && ((cyc - m_start) < H)));
    chk("m_busy", 32'(if0.busy),     32'(m_active));
    chk("m_done", 32'(if0.done),     32'(m_active && (cyc == m_start + H)));
    chk("m_ovf",  32'(if0.overflow), 32'(m_ovf));
    chk("m_pend", 32'(if0.pend_cnt), 32'(m_pend));
  endtask

  // Drive inputs for the current cycle, advance one edge, then check the new cycle.
  task automatic cycle(input bit t0, input bit t1, input bit a1);
    if0.trig = t0;
    if1.trig = t1;
    if1.ack  = a1;
    @(posedge clk);
    #1;
    cyc++;
    model_step(t0, cyc);
    if0.trig = 1'b0;
    if1.trig = 1'b0;
    if1.ack  = 1'b0;
    chk_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    m_reset();
  endtask

  int f0;
  int n_trig;
  int ovf_seen;
  int dens;
  bit t;

  initial begin
    if0.trig = 1'b0;
    if0.ack  = 1'b0;
    if1.trig = 1'b0;
    if1.ack  = 1'b0;
    m_reset();

    // Reset state, then single trig on dut0 and the ack-held pulse on dut1.
    do_reset();
    chk("rst_out",  32'(if0.out),      32'd0);
    chk("rst_busy", 32'(if0.busy),     32'd0);
    chk("rst_done", 32'(if0.done),     32'd0);
    chk("rst_ovf",  32'(if0.overflow), 32'd0);
    chk("rst_pend", 32'(if0.pend_cnt), 32'd0);
    while (cyc < 23) begin
      cycle(cyc == 10, cyc == 10, (cyc == 5) || (cyc == 20));
      if (cyc == 6)  chk("t4_idle_ack_busy", 32'(if1.busy), 32'd0);
      if (cyc == 10) chk("t1_out10", 32'(if0.out), 32'd0);
      if (cyc == 11) chk("t1_out11", 32'(if0.out), 32'd1);
      if (cyc == 14) chk("t1_out14", 32'(if0.out), 32'd1);
      if (cyc == 15) chk("t1_out15", 32'(if0.out), 32'd0);
      if (cyc == 15) chk("t1_done15", 32'(if0.done), 32'd1);
      if (cyc == 16) chk("t1_busy16", 32'(if0.busy), 32'd1);
      if (cyc == 16) chk("t1_done16", 32'(if0.done), 32'd0);
      if (cyc == 17) chk("t1_busy17", 32'(if0.busy), 32'd0);
      if (cyc == 16) chk("t4_out16", 32'(if1.out), 32'd1);
      if (cyc == 20) chk("t4_out20", 32'(if1.out), 32'd1);
      if (cyc == 21) chk("t4_out21", 32'(if1.out), 32'd0);
      if (cyc == 21) chk("t4_done21", 32'(if1.done), 32'd1);
      if (cyc == 22) chk("t4_done22", 32'(if1.done), 32'd0);
    end

    // One queued trigger.
    do_reset();
    while (cyc < 24) begin
      cycle((cyc == 10) || (cyc == 12), 1'b0, 1'b0);
      if (cyc == 12) chk("t2_pend12", 32'(if0.pend_cnt), 32'd0);
      if (cyc == 13) chk("t2_pend13", 32'(if0.pend_cnt), 32'd1);
      if (cyc == 16) chk("t2_pend16", 32'(if0.pend_cnt), 32'd1);
      if (cyc == 17) chk("t2_pend17", 32'(if0.pend_cnt), 32'd0);
      if (cyc == 17) chk("t2_out17", 32'(if0.out), 32'd1);
      if (cyc == 20) chk("t2_out20", 32'(if0.out), 32'd1);
      if (cyc == 21) chk("t2_out21", 32'(if0.out), 32'd0);
      if (cyc == 21) chk("t2_done21", 32'(if0.done), 32'd1);
    end

    // Queue fills and overflows once.
    do_reset();
    f0 = det_falls;
    while (cyc < 45) begin
      cycle((cyc >= 10) && (cyc <= 14), 1'b0, 1'b0);
      if (cyc == 12) chk("t3_pend12", 32'(if0.pend_cnt), 32'd1);
      if (cyc == 13) chk("t3_pend13", 32'(if0.pend_cnt), 32'd2);
      if (cyc == 14) chk("t3_pend14", 32'(if0.pend_cnt), 32'd3);
      if (cyc == 14) chk("t3_ovf14", 32'(if0.overflow), 32'd0);
      if (cyc == 15) chk("t3_ovf15", 32'(if0.overflow), 32'd1);
      if (cyc == 16) chk("t3_ovf16", 32'(if0.overflow), 32'd0);
    end
    chk("t3_pulses", 32'(det_falls - f0), 32'd4);

    // Async reset in the middle of a high phase.
    do_reset();
    while (cyc < 12) cycle((cyc == 10) || (cyc == 11), 1'b0, 1'b0);
    chk("t5_pre_pend", 32'(if0.pend_cnt), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_out",  32'(if0.out),      32'd0);
    chk("t5_rst_busy", 32'(if0.busy),     32'd0);
    chk("t5_rst_pend", 32'(if0.pend_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 13;
    m_reset();
    f0 = det_falls;
    while (cyc < 28) begin
      cycle(cyc == 20, 1'b0, 1'b0);
      if (cyc == 20) chk("t5_out20", 32'(if0.out), 32'd0);
      if (cyc == 21) chk("t5_out21", 32'(if0.out), 32'd1);
      if (cyc == 24) chk("t5_out24", 32'(if0.out), 32'd1);
      if (cyc == 25) chk("t5_out25", 32'(if0.out), 32'd0);
    end
    chk("t5_pulses", 32'(det_falls - f0), 32'd1);

    // Random loopback into the detector.
    do_reset();
    f0       = det_falls;
    n_trig   = 0;
    ovf_seen = 0;
    while (n_trig < 200) begin
      dens = ((n_trig / 50) % 2 == 0) ? 12 : 45;
      t    = ($urandom_range(0, 99) < dens);
      if (t) n_trig++;
      cycle(t, 1'b0, 1'b0);
      if (if0.overflow === 1'b1) ovf_seen++;
      chk("t6_pend_bound", 32'(if0.pend_cnt <= PMAX), 32'd1);
    end
    repeat ((PMAX + 1) * (H + L) + 6) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (if0.overflow === 1'b1) ovf_seen++;
    end
    chk("t6_pulses", 32'(det_falls - f0), 32'(m_pulses));
    chk("t6_accepted", 32'(det_falls - f0 + int'(if0.pend_cnt)), 32'(200 - ovf_seen));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
